// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory port between I- and D-caches.
// Keeps a write-back's grant for its refill read; a watchdog aborts stuck transactions.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              i_rd,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rdy,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rdy,
    output logic              err,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_REL
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last_d;
    logic              r_own_d;
    logic              r_op_wr;
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_i_rdy;
    logic              r_d_rdy;
    logic              r_err;
    logic              r_mem_rd;
    logic              r_mem_wr;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_own_rd;
    logic              w_tmo;
    logic              w_end;
    logic              w_grant;
    logic              w_gnt_d;
    logic              w_sel_wr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign i_rdy     = r_i_rdy;
    assign d_rdy     = r_d_rdy;
    assign err       = r_err;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign w_i_req     = i_rd | i_wr;
    assign w_d_req     = d_rd | d_wr;
    assign w_own_rd    = r_own_d ? (d_rd & ~d_wr) : (i_rd & ~i_wr);
    assign w_tmo       = (r_cnt == CW'(TIMEOUT - 1));
    assign w_end       = mem_rdy | w_tmo;
    assign w_sel_wr    = w_gnt_d ? d_wr : i_wr;
    assign w_sel_addr  = w_gnt_d ? d_addr : i_addr;
    assign w_sel_wdata = w_gnt_d ? d_wdata : i_wdata;

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // r_err is high during RELEASE only after an abort, which vetoes the lock
    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_gnt_d = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_i_req | w_d_req) begin
                    w_grant = 1'b1;
                    w_gnt_d = w_d_req & (~w_i_req | ~r_last_d);
                    w_next  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_end) begin
                    w_next = S_REL;
                end
            end
            S_REL: begin
                if (r_op_wr & ~r_err & w_own_rd) begin
                    w_grant = 1'b1;
                    w_gnt_d = r_own_d;
                    w_next  = S_BUSY;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_last_d  <= 1'b0;
            r_own_d   <= 1'b0;
            r_op_wr   <= 1'b0;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_rdy   <= 1'b0;
            r_d_rdy   <= 1'b0;
            r_err     <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
        end else begin
            r_i_rdy <= 1'b0;
            r_d_rdy <= 1'b0;
            r_err   <= 1'b0;
            if (w_grant) begin
                r_last_d <= w_gnt_d;
                r_own_d  <= w_gnt_d;
                r_op_wr  <= w_sel_wr;
                r_addr   <= w_sel_addr;
                r_wdata  <= w_sel_wdata;
                r_mem_rd <= ~w_sel_wr;
                r_mem_wr <= w_sel_wr;
                r_cnt    <= '0;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + CW'(1);
                if (w_end) begin
                    r_mem_rd <= 1'b0;
                    r_mem_wr <= 1'b0;
                    r_err    <= ~mem_rdy;
                    if (r_own_d) begin
                        r_d_rdy <= 1'b1;
                    end else begin
                        r_i_rdy <= 1'b1;
                    end
                    if (mem_rdy & ~r_op_wr) begin
                        if (r_own_d) begin
                            r_d_rdata <= mem_rdata;
                        end else begin
                            r_i_rdata <= mem_rdata;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          i_rd, i_wr, d_rd, d_wr;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] i_wdata, d_wdata;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          i_rdy, d_rdy, err;
    logic          mem_rd, mem_wr, mem_rdy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_b(rst_b),
        .i_rd(i_rd), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_rdy(i_rdy),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_rdy(d_rdy),
        .err(err),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one transaction in flight, a release slot after it.
    bit            m_last_d, m_active, m_own_d, m_wr, m_rel, m_ab;
    int            m_age;
    logic [AW-1:0] e_mem_addr;
    logic [DW-1:0] e_mem_wdata, e_i_rdata, e_d_rdata;
    logic          e_mem_rd, e_mem_wr, e_i_rdy, e_d_rdy, e_err;

    task automatic m_start(input bit dsel);
        m_active    = 1;
        m_own_d     = dsel;
        m_wr        = dsel ? d_wr : i_wr;
        m_age       = 0;
        e_mem_addr  = dsel ? d_addr : i_addr;
        e_mem_wdata = dsel ? d_wdata : i_wdata;
        e_mem_rd    = !m_wr;
        e_mem_wr    = m_wr;
    endtask

    task automatic m_finish(input bit aborted);
        m_active = 0;
        m_rel    = 1;
        m_ab     = aborted;
        e_mem_rd = 0;
        e_mem_wr = 0;
        e_err    = aborted;
        if (m_own_d) e_d_rdy = 1; else e_i_rdy = 1;
        if (!aborted && !m_wr) begin
            if (m_own_d) e_d_rdata = mem_rdata; else e_i_rdata = mem_rdata;
        end
    endtask

    always @(posedge clk) begin
        if (rst_b) begin
            m_last_d = 0; m_active = 0; m_own_d = 0; m_wr = 0;
            m_rel = 0; m_ab = 0; m_age = 0;
            e_mem_addr = '0; e_mem_wdata = '0; e_i_rdata = '0; e_d_rdata = '0;
            e_mem_rd = 0; e_mem_wr = 0; e_i_rdy = 0; e_d_rdy = 0; e_err = 0;
        end else begin
            e_i_rdy = 0; e_d_rdy = 0; e_err = 0;
            if (m_rel) begin
                m_rel = 0;
                if (m_wr && !m_ab && (m_own_d ? (d_rd && !d_wr) : (i_rd && !i_wr)))
                    m_start(m_own_d);
            end else if (m_active) begin
                m_age++;
                if (mem_rdy) m_finish(0);
                else if (m_age == TMO) m_finish(1);
            end else if ((d_rd || d_wr) && (!(i_rd || i_wr) || !m_last_d)) begin
                m_last_d = 1;
                m_start(1);
            end else if (i_rd || i_wr) begin
                m_last_d = 0;
                m_start(0);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mem_rd", 64'(mem_rd), 64'(e_mem_rd));
            chk("mem_wr", 64'(mem_wr), 64'(e_mem_wr));
            chk("mem_addr", 64'(mem_addr), 64'(e_mem_addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(e_mem_wdata));
            chk("i_rdy", 64'(i_rdy), 64'(e_i_rdy));
            chk("d_rdy", 64'(d_rdy), 64'(e_d_rdy));
            chk("err", 64'(err), 64'(e_err));
            chk("i_rdata", 64'(i_rdata), 64'(e_i_rdata));
            chk("d_rdata", 64'(d_rdata), 64'(e_d_rdata));
        end
    end

    // Memory responder: mem_rdy after mem_delay strobe cycles (-1 = never)
    int            mem_delay = 0;
    int            stb_n = 0;
    bit            use_fixed = 0;
    logic [DW-1:0] fixed_rdata = '0;
    bit            prev_stb = 0;
    logic [AW-1:0] log_addr[$];
    bit            log_wr[$];

    always @(negedge clk) begin
        if (cmp_en && (mem_rd || mem_wr)) begin
            stb_n++;
            mem_rdy = (mem_delay >= 0) && (stb_n - 1 == mem_delay);
            if (!prev_stb) begin
                log_addr.push_back(mem_addr);
                log_wr.push_back(mem_wr);
            end
            prev_stb = 1;
        end else begin
            stb_n    = 0;
            mem_rdy  = 0;
            prev_stb = 0;
        end
        mem_rdata = use_fixed ? fixed_rdata : (mem_addr ^ 32'hA5A5_0000);
    end

    task automatic wait_rdy(input bit dsel, output int n, output int s);
        bit done;
        n = 0; s = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            n++;
            if (mem_rd || mem_wr) s++;
            if ((dsel ? d_rdy : i_rdy) === 1'b1) done = 1;
            else if (n >= 100) begin
                n_cmp++; n_bad++;
                $display("FAIL rdy_wait client_d=%0d actual=no rdy required=rdy within 100", dsel);
                done = 1;
            end
        end
    endtask

    task automatic run_client(input bit dsel, input logic [AW-1:0] base, input int cnt);
        int n, s;
        if (dsel) begin d_rd = 1; d_addr = base; end
        else begin i_rd = 1; i_addr = base; end
        for (int j = 0; j < cnt; j++) begin
            wait_rdy(dsel, n, s);
            if (dsel) begin
                if (j + 1 < cnt) d_addr = base + AW'(j + 1); else d_rd = 0;
            end else begin
                if (j + 1 < cnt) i_addr = base + AW'(j + 1); else i_rd = 0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, s;
        rst_b = 1; mem_rdy = 0; mem_rdata = '0;
        i_rd = 0; i_wr = 0; i_addr = '0; i_wdata = '0;
        d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
        repeat (2) @(negedge clk);
        cmp_en = 1;
        chk("rst_mem_rd", 64'(mem_rd), 64'h0);
        chk("rst_mem_addr", 64'(mem_addr), 64'h0);
        chk("rst_d_rdata", 64'(d_rdata), 64'h0);
        rst_b = 0;

        // single D read
        use_fixed = 1; fixed_rdata = 32'hCAFE_0001; mem_delay = 2;
        d_rd = 1; d_addr = 32'h100;
        @(negedge clk);
        chk("A_strobe", 64'(mem_rd), 64'h1);
        chk("A_addr", 64'(mem_addr), 64'h100);
        wait_rdy(1, n, s);
        chk("A_latency", 64'(n), 64'd3);
        chk("A_rdata", 64'(d_rdata), 64'hCAFE_0001);
        chk("A_err", 64'(err), 64'h0);
        chk("A_irdy", 64'(i_rdy), 64'h0);
        d_rd = 0; use_fixed = 0;
        @(negedge clk);
        chk("A_rdy_width", 64'(d_rdy), 64'h0);

        // round-robin alternation from reset
        rst_b = 1; @(negedge clk); rst_b = 0;
        log_addr.delete(); log_wr.delete();
        mem_delay = 0;
        fork
            run_client(0, 32'h1000, 2);
            run_client(1, 32'h2000, 2);
        join
        repeat (2) @(negedge clk);
        chk("B_count", 64'(log_addr.size()), 64'd4);
        if (log_addr.size() == 4) begin
            chk("B_g0", 64'(log_addr[0]), 64'h2000);
            chk("B_g1", 64'(log_addr[1]), 64'h1000);
            chk("B_g2", 64'(log_addr[2]), 64'h2001);
            chk("B_g3", 64'(log_addr[3]), 64'h1001);
        end

        // write-back then locked refill
        log_addr.delete(); log_wr.delete();
        mem_delay = 1;
        d_wr = 1; d_addr = 32'h2000; d_wdata = 32'h55;
        i_rd = 1; i_addr = 32'h1100;
        wait_rdy(1, n, s);
        d_wr = 0; d_rd = 1; d_addr = 32'h4000;
        wait_rdy(1, n, s);
        d_rd = 0;
        wait_rdy(0, n, s);
        i_rd = 0;
        @(negedge clk);
        chk("C_count", 64'(log_addr.size()), 64'd3);
        if (log_addr.size() == 3) begin
            chk("C_t0_addr", 64'(log_addr[0]), 64'h2000);
            chk("C_t0_wr", 64'(log_wr[0]), 64'h1);
            chk("C_t1_addr", 64'(log_addr[1]), 64'h4000);
            chk("C_t1_wr", 64'(log_wr[1]), 64'h0);
            chk("C_t2_addr", 64'(log_addr[2]), 64'h1100);
        end
        chk("C_d_rdata", 64'(d_rdata), 64'hA5A5_4000);
        chk("C_i_rdata", 64'(i_rdata), 64'hA5A5_1100);

        // watchdog abort
        mem_delay = -1;
        i_rd = 1; i_addr = 32'h1200;
        wait_rdy(0, n, s);
        chk("D_strobe_cycles", 64'(s), 64'd8);
        chk("D_latency", 64'(n), 64'd9);
        chk("D_err", 64'(err), 64'h1);
        chk("D_rdata_kept", 64'(i_rdata), 64'hA5A5_1100);
        i_rd = 0;
        @(negedge clk);
        chk("D_err_width", 64'(err), 64'h0);
        mem_delay = 0;
        i_rd = 1; i_addr = 32'h1300;
        wait_rdy(0, n, s);
        chk("D_next_rdata", 64'(i_rdata), 64'hA5A5_1300);
        chk("D_next_err", 64'(err), 64'h0);
        i_rd = 0;
        @(negedge clk);

        // mem_rdy coinciding with the last watchdog cycle
        mem_delay = TMO - 1;
        d_rd = 1; d_addr = 32'h2300;
        wait_rdy(1, n, s);
        chk("E_strobe_cycles", 64'(s), 64'd8);
        chk("E_err", 64'(err), 64'h0);
        chk("E_rdata", 64'(d_rdata), 64'hA5A5_2300);
        d_rd = 0;
        @(negedge clk);

        // reset during a write
        mem_delay = -1;
        d_wr = 1; d_addr = 32'h2400; d_wdata = 32'h77;
        repeat (3) @(negedge clk);
        chk("F_wr_busy", 64'(mem_wr), 64'h1);
        rst_b = 1; d_wr = 0;
        @(negedge clk);
        chk("F_mem_wr", 64'(mem_wr), 64'h0);
        chk("F_mem_addr", 64'(mem_addr), 64'h0);
        chk("F_d_rdata", 64'(d_rdata), 64'h0);
        chk("F_i_rdata", 64'(i_rdata), 64'h0);
        rst_b = 0; mem_delay = 0;
        i_rd = 1; i_addr = 32'h1500;
        d_rd = 1; d_addr = 32'h2500;
        @(negedge clk);
        chk("F_tie_addr", 64'(mem_addr), 64'h2500);
        chk("F_tie_rd", 64'(mem_rd), 64'h1);
        wait_rdy(1, n, s);
        d_rd = 0;
        wait_rdy(0, n, s);
        i_rd = 0;
        chk("F_i_rdata", 64'(i_rdata), 64'hA5A5_1500);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the instruction cache (client I) and the data cache (client D).
- Each cache issues its memory requests on a level rd/wr/addr/wdata interface and holds them until it sees a one-cycle rdy pulse.
- The arbiter grants one client at a time using round-robin, drives the memory port from latched request registers, and returns the read data and rdy to the granted client.
- When a client's write-back is followed immediately by its refill read, the arbiter keeps that client's grant for the read.
- A watchdog aborts any memory transaction that does not complete.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, maximum cycles waiting for mem_rdy before abort (must be >= 2)

Ports:
clk  in  1  clock, all logic on rising edge
rst_b  in  1  synchronous reset, active-high (1 = reset)
i_rd  in  1  client I read request (level)
i_wr  in  1  client I write request (level)
i_addr  in  ADDR_W  client I address
i_wdata  in  DATA_W  client I write data
i_rdata  out  DATA_W  read data to client I
i_rdy  out  1  one-cycle completion pulse to client I
d_rd, d_wr, d_addr, d_wdata, d_rdata, d_rdy  same as the client I ports, for client D
err  out  1  one-cycle pulse issued together with the rdy of an aborted transaction
mem_rd  out  1  memory read strobe (level, held until mem_rdy)
mem_wr  out  1  memory write strobe (level, held until mem_rdy)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid when mem_rdy=1
mem_rdy  in  1  memory completion, sampled only in BUSY

Behaviour:
- All registered. Reset is synchronous and overrides everything, including a transaction in flight.
- Reset values:
  - state = IDLE.
  - All outputs = 0.
  - Watchdog counter = 0.
  - Round-robin pointer: last_grant = I, so D wins the first tie.
  - Memory is not notified when a transaction is abandoned by reset.
- A client's request is active when rd or wr is 1. If rd and wr are both 1, the request is a write.
- IDLE:
  - No request: stay in IDLE.
  - One requester: grant it.
  - Both requesting: grant the client that is not last_grant.
  - On a grant: latch owner, op, addr and wdata (latched addr/wdata drive mem_addr/mem_wdata); set mem_rd or mem_wr; clear the counter; update last_grant; go to BUSY.
  - Memory strobes rise in the cycle after the request is first seen in IDLE.
- BUSY:
  - Strobes and mem_addr/mem_wdata are held constant. Client inputs are ignored.
  - Counter increments each cycle.
  - mem_rdy=1:
    - Clear the strobes.
    - For a read, latch mem_rdata into the owner's rdata.
    - Pulse the owner's rdy next cycle.
    - Go to RELEASE.
  - Counter == TIMEOUT-1 with mem_rdy=0:
    - Clear the strobes.
    - Pulse the owner's rdy and err together.
    - Leave rdata unchanged.
    - Go to RELEASE.
  - If mem_rdy and the timeout coincide, mem_rdy wins: normal completion, no err.
- RELEASE (one cycle, coincides with the rdy pulse):
  - Lock: if the completed op was a write (not aborted) and the same owner now presents a read, regrant that owner without round-robin, latch the new request and go to BUSY. last_grant is unchanged.
  - Otherwise go to IDLE. The non-owner's pending request is then granted on the next cycle because last_grant points at the owner.
- rdata holds its value until the next read completes for that client.
- rdy and err are exactly one cycle wide. They are never asserted to the non-owner.
- Latency:
  - Request seen in IDLE at cycle t → strobe at t+1.
  - mem_rdy sampled at t+1+k (k >= 0) → client rdy at t+2+k.
  - Minimum turnaround: 3 cycles from request to rdy.
- Fairness: with both clients requesting continuously and no locks, grants alternate D, I, D, I. A client waits at most one foreign transaction (plus that transaction's locked refill, if any).

Test Plan:
- Reset, then d_rd=1, d_addr=0x100, mem_rdy returned 2 cycles after mem_rd rises with mem_rdata=0xCAFE0001 → mem_rd=1 / mem_addr=0x100 one cycle after the request; d_rdata=0xCAFE0001 with a single d_rdy pulse; i_rdy stays 0; err=0.
- i_rd and d_rd both asserted from reset, memory answers every transaction in 1 cycle → grant order D, I, D, I; each client's rdy pulses alternate and never overlap.
- d_wr=1 (addr 0x2000, wdata 0x55), then on d_rdy switch to d_rd=1 (addr 0x4000) while i_rd=1 → the second memory transaction is a D read of 0x4000 (lock); I is served only after it.
- i_rd with mem_rdy held at 0, TIMEOUT=8 → strobe drops after 8 BUSY cycles; i_rdy and err pulse together; i_rdata unchanged; the next request is serviced normally.
- rst_b=1 asserted while BUSY with mem_wr=1 → mem_wr=0 and all outputs 0 on the next edge; state IDLE; a D-vs-I tie after reset grants D first.
- mem_rdy arriving in the same cycle the counter reaches TIMEOUT-1 → normal completion: rdata updated, err=0.
